// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling and framing-error detection.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic       clk_in,
  input  logic       sys_rst_n,
  input  logic       rxd_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       frame_err_out,
  output logic       parity_err_out,
  output logic       busy_out
);

  localparam int unsigned BIT_CYCLES  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CntW        = $clog2(BIT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CntW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            bit_done, half_done;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
`endif

  assign bit_done  = (cyc_cnt_q == CntW'(BIT_CYCLES - 1));
  assign half_done = (cyc_cnt_q == CntW'(HALF_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q + CntW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        cyc_cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        // A line that is high again at mid start bit was only a glitch.
        if (half_done) begin
          cyc_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (bit_done) begin
          cyc_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bit_done) begin
          cyc_cnt_d = '0;
          par_bad_d = (rx_s_q != ^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          cyc_cnt_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // Hold off until the line idles so a break cannot retrigger a frame.
        cyc_cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        cyc_cnt_d = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cyc_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rxd_in;
      rx_s_q    <= rx_meta_q;
      cyc_cnt_q <= cyc_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign frame_err_out = ferr_q;
  assign busy_out      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err_out = perr_q;
`else
  assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver pushes the expected strobe per frame, a monitor
// pops and checks kind, data, latency and busy whenever a strobe appears.
module tb_uart_rx;

  localparam int unsigned CF   = 1_600_000;
  localparam int unsigned BR   = 100_000;
  localparam int unsigned BIT  = CF / BR;
  localparam int unsigned HALF = BIT / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 10;
`else
  localparam int unsigned FRAME_BITS = 9;
`endif
  // Falling edge driven at a negedge: 2 sync + 1 detect + half bit + remaining bits.
  localparam int unsigned LATENCY = 3 + HALF + FRAME_BITS * BIT;

  localparam int KValid = 0;
  localparam int KFerr  = 1;
  localparam int KPerr  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data_out;
  logic       valid_out, frame_err_out, parity_err_out, busy_out;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  logic [7:0] last_good = 8'h00;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx #(
    .CLOCK_FREQ(CF),
    .BAUD_RATE (BR)
  ) dut (
    .clk_in        (clk),
    .sys_rst_n     (rst_n),
    .rxd_in        (rxd),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .frame_err_out (frame_err_out),
    .parity_err_out(parity_err_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Called at a negedge; returns at a negedge after the stop bit period.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    exp_t e;
    logic par_bad;
    par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad = par_flip;
`endif
    e.fall = cyc;
    if (!stop_b) begin
      e.kind = KFerr;
      e.data = last_good;
    end else if (par_bad) begin
      e.kind = KPerr;
      e.data = last_good;
    end else begin
      e.kind    = KValid;
      e.data    = d;
      last_good = d;
    end
    exp_q.push_back(e);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ par_flip;
    repeat (BIT) @(negedge clk);
`endif
    rxd = stop_b;
    repeat (BIT) @(negedge clk);
  endtask

  exp_t mon_e;
  int   mon_kind;
  int   mon_n;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_n = int'(valid_out) + int'(frame_err_out) + int'(parity_err_out);
      if (mon_n != 0) begin
        mon_kind = (mon_n > 1) ? 3 : valid_out ? KValid : frame_err_out ? KFerr : KPerr;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", mon_kind, -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", mon_kind, mon_e.kind);
          check("data_out", int'(data_out), int'(mon_e.data));
          check("latency", cyc - mon_e.fall, int'(LATENCY));
          check("busy_at_strobe", int'(busy_out), (mon_e.kind == KFerr) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", int'(data_out), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_ferr", int'(frame_err_out), 0);
    check("rst_perr", int'(parity_err_out), 0);
    check("rst_busy", int'(busy_out), 0);
    rst_n = 1'b1;
    repeat (BIT) @(negedge clk);

    send_frame(8'hA5, 1'b1);
    repeat (BIT) @(negedge clk);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (BIT) @(negedge clk);

    // Short glitch: START must reject it.
    rxd = 1'b0;
    repeat (HALF - 3) @(negedge clk);
    check("glitch_busy_high", int'(busy_out), 1);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_back_idle", int'(busy_out), 0);

    // Break after a bad stop bit: stay busy until the line is released.
    send_frame(8'h3C, 1'b0);
    repeat (5 * BIT) @(negedge clk);
    check("break_busy", int'(busy_out), 1);
    rxd = 1'b1;
    @(negedge clk);
    check("release_busy_hold", int'(busy_out), 1);
    repeat (3) @(negedge clk);
    check("release_idle", int'(busy_out), 0);
    check("ferr_data_kept", int'(data_out), 8'h55);
    repeat (BIT) @(negedge clk);

    // Reset during data bit 4 abandons the frame.
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
    end
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_data", int'(data_out), 0);
    check("midrst_busy", int'(busy_out), 0);
    last_good = 8'h00;
    rst_n = 1'b1;
    repeat (BIT) @(negedge clk);
    send_frame(8'h81, 1'b1);
    repeat (BIT) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    repeat (BIT) @(negedge clk);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    repeat (BIT) @(negedge clk);
    par_flip = 1'b0;
`endif

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       stop_b;
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      par_flip = ($urandom_range(0, 3) == 0);
`endif
      send_frame(d, stop_b);
      if (!stop_b) begin
        repeat ($urandom_range(1, 3) * BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 2) * BIT) @(negedge clk);
      end
    end

    repeat (3 * BIT) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_busy", int'(busy_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
